// File: rtl/dpram_arb_pkg.sv
// Shared state encoding and index helper for the DPRAM port-A arbiter.
// Used by rr_arbiter and dpram_port_arbiter.
package dpram_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } arb_state_e;

    // Folds an index in [0, 2n) back into [0, n) without a divider.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search starting at ptr_q.
// Produces a one-hot grant and the winner index in the same cycle.
module rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  win_o,
    output logic            grant_any_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // The grant depends only on req_i, en_i and ptr_q, so there is no path from ready back into ready.
    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        win_o       = '0;
        grant_any_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = wrap_idx(int'(ptr_q) + i, NREQ);
            if (en_i && !grant_any_o && req_i[idx]) begin
                grant_any_o  = 1'b1;
                grant_o[idx] = 1'b1;
                win_o        = IDW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any_o) begin
            ptr_d = IDW'(wrap_idx(int'(win_o) + 1, NREQ));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares DPRAM port A between NREQ requesters with round-robin arbitration.
// Optional power-up clear of the whole RAM is enabled by defining DPRAM_ARB_CLEAR_EN.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DP   = 512,
    parameter int DW   = 8,
    parameter int AW   = $clog2(DP),
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               CLKA,
    input  logic               rstb,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_rdata,
    output logic               busy,
    output logic               ram_ce,
    output logic               ram_rst,
    output logic               ram_wr,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win;
    logic            grant_any;
    logic            rd_grant;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i       (CLKA),
        .rst_i       (rstb),
        .en_i        (state_q == ST_RUN),
        .req_i       (req_valid),
        .grant_o     (grant),
        .win_o       (win),
        .grant_any_o (grant_any)
    );

    assign req_ready = grant;
    assign rd_grant  = grant_any && !req_wr[win];

`ifdef DPRAM_ARB_CLEAR_EN
    logic [AW-1:0] clr_addr_q;
    logic [AW-1:0] clr_addr_d;
    logic          clearing;

    assign clearing = (state_q == ST_CLEAR);
    assign busy     = clearing;

    always_comb begin
        clr_addr_d = clr_addr_q;
        if (clearing) begin
            clr_addr_d = clr_addr_q + AW'(1);
        end
    end

    // A reset in the middle of a clear restarts it from address 0.
    always_ff @(posedge CLKA) begin
        if (rstb) begin
            clr_addr_q <= '0;
        end else begin
            clr_addr_q <= clr_addr_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
`ifdef DPRAM_ARB_CLEAR_EN
                state_d = ST_CLEAR;
`else
                state_d = ST_RUN;
`endif
            end
            ST_CLEAR: begin
`ifdef DPRAM_ARB_CLEAR_EN
                if (clr_addr_q == AW'(DP - 1)) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge CLKA) begin
        if (rstb) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ram_ce   = grant_any;
        ram_wr   = grant_any && req_wr[win];
        ram_addr = addr_arr[win];
        ram_din  = wdata_arr[win];
`ifdef DPRAM_ARB_CLEAR_EN
        if (clearing) begin
            ram_ce   = 1'b1;
            ram_wr   = 1'b1;
            ram_addr = clr_addr_q;
            ram_din  = '0;
        end
`endif
    end

    // Resetting the RAM output register along with the arbiter keeps rsp_rdata clean after reset.
    assign ram_rst = (state_q == ST_RESET);

    always_ff @(posedge CLKA) begin
        if (rstb) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rd_grant;
            if (rd_grant) begin
                rsp_id_q <= win;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed self-checking bench for dpram_port_arbiter with a behavioural port-A RAM.
// Define DPRAM_ARB_CLEAR_EN for both files to also exercise the power-up clear.
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int DP   = 512;
    localparam int DW   = 8;
    localparam int AW   = 9;
    localparam int IDW  = 2;

    logic               CLKA = 1'b0;
    logic               rstb = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_wr = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_rdata;
    logic               busy;
    logic               ram_ce;
    logic               ram_rst;
    logic               ram_wr;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout = '0;

    logic [DW-1:0]      mem [DP];

    int n_chk  = 0;
    int n_fail = 0;

    dpram_port_arbiter #(
        .NREQ (NREQ),
        .DP   (DP),
        .DW   (DW)
    ) dut (
        .CLKA      (CLKA),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ram_ce    (ram_ce),
        .ram_rst   (ram_rst),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 CLKA = ~CLKA;

    // Port A of the RAM: registered read, output reset, no read during write.
    always @(posedge CLKA) begin
        if (ram_rst) begin
            ram_dout <= '0;
        end else if (ram_ce) begin
            if (ram_wr) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload();
        for (int i = 0; i < DP; i++) mem[i] = 8'(i + 'h30);
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input int d);
        req_valid[i]          = v;
        req_wr[i]             = w;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    // Leaves the time at 1 unit after a posedge with the arbiter in RUN.
    task automatic do_reset();
        req_valid = '0;
        rstb      = 1'b1;
        repeat (2) @(posedge CLKA);
        #1 rstb = 1'b0;
        @(posedge CLKA); #1;
`ifdef DPRAM_ARB_CLEAR_EN
        for (int i = 0; i < DP + 8 && busy; i++) begin
            @(posedge CLKA); #1;
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_done: busy=%b required 0", busy);
        end
`endif
        preload();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        rstb = 1'b1;
        @(posedge CLKA);
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b required 0000", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_chk++; if (rsp_id !== 2'd0)       begin n_fail++; $display("FAIL rst_rsp_id: got %0d required 0", rsp_id); end
        n_chk++; if (ram_ce !== 1'b0)       begin n_fail++; $display("FAIL rst_ram_ce: got %b required 0", ram_ce); end
        n_chk++; if (ram_wr !== 1'b0)       begin n_fail++; $display("FAIL rst_ram_wr: got %b required 0", ram_wr); end
        n_chk++; if (ram_rst !== 1'b1)      begin n_fail++; $display("FAIL rst_ram_rst: got %b required 1", ram_rst); end
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_chk++; if (dut.u_arb.ptr_q !== 2'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d required 0", dut.u_arb.ptr_q); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] exp_id   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] exp_data [8] = '{8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3A, 8'h3B, 8'h3C, 8'h3D};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 10 + i, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLKA);
            n_chk++; if (req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL rr_grant c=%0d: got %b required %b", c, req_ready, exp_rdy[c]); end
            if (c > 0) begin
                n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d: got %b required 1", c, rsp_valid); end
                n_chk++; if (rsp_id !== exp_id[c-1]) begin n_fail++; $display("FAIL rr_rsp_id c=%0d: got %0d required %0d", c, rsp_id, exp_id[c-1]); end
                n_chk++; if (rsp_rdata !== exp_data[c-1]) begin n_fail++; $display("FAIL rr_rdata c=%0d: got %h required %h", c, rsp_rdata, exp_data[c-1]); end
            end
            @(posedge CLKA); #1;
        end
        req_valid = '0;
        @(negedge CLKA);
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_last_valid: got %b required 1", rsp_valid); end
        n_chk++; if (rsp_id !== 2'd3)    begin n_fail++; $display("FAIL rr_last_id: got %0d required 3", rsp_id); end
        n_chk++; if (rsp_rdata !== 8'h3D) begin n_fail++; $display("FAIL rr_last_rdata: got %h required 3d", rsp_rdata); end
        @(posedge CLKA); #1;
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(1, 1'b1, 1'b1, 'h020, 'h5A);
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wr_ready: got %b required 0010", req_ready); end
        n_chk++; if (ram_ce !== 1'b1 || ram_wr !== 1'b1) begin n_fail++; $display("FAIL wr_ce_wr: got ce=%b wr=%b required 1 1", ram_ce, ram_wr); end
        n_chk++; if (ram_addr !== 9'h020) begin n_fail++; $display("FAIL wr_addr: got %h required 020", ram_addr); end
        n_chk++; if (ram_din !== 8'h5A)   begin n_fail++; $display("FAIL wr_din: got %h required 5a", ram_din); end
        @(posedge CLKA); #1;
        set_req(1, 1'b0, 1'b0, 0, 0);
        set_req(3, 1'b1, 1'b0, 'h020, 0);
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rd_ready: got %b required 1000", req_ready); end
        n_chk++; if (ram_wr !== 1'b0)   begin n_fail++; $display("FAIL rd_ram_wr: got %b required 0", ram_wr); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b required 0", rsp_valid); end
        @(posedge CLKA); #1;
        req_valid = '0;
        @(negedge CLKA);
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %b required 1", rsp_valid); end
        n_chk++; if (rsp_id !== 2'd3)    begin n_fail++; $display("FAIL rd_rsp_id: got %0d required 3", rsp_id); end
        n_chk++; if (rsp_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_rdata: got %h required 5a", rsp_rdata); end
        @(posedge CLKA); #1;
    endtask

    task automatic test_single_req();
        do_reset();
        set_req(2, 1'b1, 1'b0, 12, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLKA);
            n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready c=%0d: got %b required 0100", c, req_ready); end
            @(posedge CLKA); #1;
        end
        n_chk++; if (dut.u_arb.ptr_q !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d required 3", dut.u_arb.ptr_q); end
        set_req(0, 1'b1, 1'b0, 10, 0);
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_first: got %b required 0001", req_ready); end
        @(posedge CLKA); #1;
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_second: got %b required 0100", req_ready); end
        n_chk++; if (rsp_id !== 2'd0 || rsp_rdata !== 8'h3A) begin n_fail++; $display("FAIL wrap_rsp: got id=%0d data=%h required 0 3a", rsp_id, rsp_rdata); end
        @(posedge CLKA); #1;
        req_valid = '0;
    endtask

    task automatic test_reset_midread();
        do_reset();
        set_req(0, 1'b1, 1'b0, 10, 0);
        rstb = 1'b1;
        @(negedge CLKA);
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant: got %b required 0001", req_ready); end
        @(posedge CLKA); #1;
        rstb = 1'b0;
        @(negedge CLKA);
        n_chk++; if (rsp_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b required 0000", req_ready); end
        n_chk++; if (dut.u_arb.ptr_q !== 2'd0) begin n_fail++; $display("FAIL mid_ptr: got %0d required 0", dut.u_arb.ptr_q); end
        n_chk++; if (ram_rst !== 1'b1)      begin n_fail++; $display("FAIL mid_ram_rst: got %b required 1", ram_rst); end
        @(posedge CLKA); #1;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLKA);
            n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d: got %b required 0", c, rsp_valid); end
            @(posedge CLKA); #1;
        end
    endtask

    task automatic test_idle();
        do_reset();
        set_req(1, 1'b1, 1'b0, 11, 0);
        @(posedge CLKA); #1;
        req_valid = '0;
        @(negedge CLKA);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3B) begin n_fail++; $display("FAIL idle_pre: got v=%b data=%h required 1 3b", rsp_valid, rsp_rdata); end
        @(posedge CLKA); #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLKA);
            n_chk++; if (ram_ce !== 1'b0)     begin n_fail++; $display("FAIL idle_ce c=%0d: got %b required 0", c, ram_ce); end
            n_chk++; if (rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL idle_rsp c=%0d: got %b required 0", c, rsp_valid); end
            n_chk++; if (ram_dout !== 8'h3B)  begin n_fail++; $display("FAIL idle_dout c=%0d: got %h required 3b", c, ram_dout); end
            @(posedge CLKA); #1;
        end
    endtask

`ifdef DPRAM_ARB_CLEAR_EN
    task automatic test_clear();
        int busy_cnt;
        int viol;
        int rd_addr [3] = '{0, 255, 511};
        busy_cnt = 0;
        viol     = 0;
        for (int i = 0; i < DP; i++) mem[i] = 8'hFF;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        rstb = 1'b1;
        repeat (2) @(posedge CLKA);
        #1 rstb = 1'b0;
        @(posedge CLKA); #1;
        while (busy && busy_cnt < 600) begin
            @(negedge CLKA);
            if (req_ready !== 4'b0000) viol++;
            busy_cnt++;
            @(posedge CLKA); #1;
        end
        req_valid = '0;
        n_chk++; if (busy_cnt != 512) begin n_fail++; $display("FAIL clear_len: got %0d cycles required 512", busy_cnt); end
        n_chk++; if (viol != 0)       begin n_fail++; $display("FAIL clear_ready: got %0d grant cycles required 0", viol); end
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 1'b0, rd_addr[k], 0);
            @(posedge CLKA); #1;
            req_valid = '0;
            @(negedge CLKA);
            n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL clear_data a=%0d: got v=%b data=%h required 1 00", rd_addr[k], rsp_valid, rsp_rdata); end
            @(posedge CLKA); #1;
        end
    endtask
`endif

    initial begin
        preload();
        test_reset();
        test_round_robin();
        test_write_read();
        test_single_req();
        test_reset_midread();
        test_idle();
`ifdef DPRAM_ARB_CLEAR_EN
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
